// File: rtl/i2c_master_gen.sv
// I2C master: byte/page write, current-address read and random read of 1..MAX_BYTES bytes.
// Each bit is four CLK_DIV-clock quarters; busy from the cycle after start until the one-cycle done pulse.
module i2c_master_gen #(
    parameter int CLK_DIV   = 125,
    parameter int MAX_BYTES = 4,
    parameter int DATA_W    = 8*MAX_BYTES,
    parameter int CNT_W     = $clog2(MAX_BYTES)+1
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [6:0]        dev_addr,
    input  logic              rw,
    input  logic              use_waddr,
    input  logic [7:0]        word_addr,
    input  logic [CNT_W-1:0]  nbytes,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              busy,
    output logic              done,
    output logic              nack,
    output logic              scl_oe,
    output logic              sda_oe,
    input  logic              scl_i,
    input  logic              sda_i
);
    localparam int                PH_W    = $clog2(CLK_DIV);
    localparam logic [PH_W-1:0]   PH_LAST = PH_W'(CLK_DIV-1);
    localparam logic [CNT_W-1:0]  MAXB    = CNT_W'(MAX_BYTES);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_START  = 4'd1;
    localparam logic [3:0] S_ADDR   = 4'd2;
    localparam logic [3:0] S_AACK   = 4'd3;
    localparam logic [3:0] S_WADDR  = 4'd4;
    localparam logic [3:0] S_WAACK  = 4'd5;
    localparam logic [3:0] S_RSTART = 4'd6;
    localparam logic [3:0] S_WDATA  = 4'd7;
    localparam logic [3:0] S_WDACK  = 4'd8;
    localparam logic [3:0] S_RDATA  = 4'd9;
    localparam logic [3:0] S_MACK   = 4'd10;
    localparam logic [3:0] S_STOP   = 4'd11;

    logic [3:0]        r_state;
    logic [1:0]        r_q;
    logic [PH_W-1:0]   r_ph;
    logic [2:0]        r_bit;
    logic [CNT_W-1:0]  r_k;
    logic [CNT_W-1:0]  r_nb;
    logic [6:0]        r_dev;
    logic              r_rw;
    logic              r_uwa;
    logic              r_rs;
    logic [7:0]        r_waddr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [7:0]        r_sh;
    logic              r_sda_s;
    logic              r_busy;
    logic              r_done;
    logic              r_nack;

    logic [CNT_W-1:0]  w_nb;
    logic [7:0]        w_tx_byte;
    logic              w_tx_bit;
    logic              w_k_last;
    logic              w_scl_oe;
    logic              w_sda_oe;
    logic              w_hold;
    logic              w_q_end;
    logic              w_sample;
    logic              w_bit_end;

    assign w_nb = (nbytes == '0) ? CNT_W'(1) : ((nbytes > MAXB) ? MAXB : nbytes);

    // After a repeated START the address byte always carries R/W=1.
    always_comb begin
        w_tx_byte = r_waddr;
        case (r_state)
            S_ADDR:  w_tx_byte = {r_dev, r_rs | (r_rw & ~r_uwa)};
            S_WDATA: w_tx_byte = r_wdata[{r_k, 3'b000} +: 8];
            default: w_tx_byte = r_waddr;
        endcase
    end

    assign w_tx_bit = w_tx_byte[3'd7 - r_bit];
    assign w_k_last = ((r_k + CNT_W'(1)) == r_nb);

    always_comb begin
        w_scl_oe = ~r_q[1];
        w_sda_oe = 1'b0;
        case (r_state)
            S_IDLE:                   w_scl_oe = 1'b0;
            S_START: begin
                w_scl_oe = r_q[1];
                w_sda_oe = 1'b1;
            end
            S_ADDR, S_WADDR, S_WDATA: w_sda_oe = ~w_tx_bit;
            S_MACK:                   w_sda_oe = ~w_k_last;
            S_RSTART:                 w_sda_oe = (r_q == 2'd3);
            S_STOP:                   w_sda_oe = (r_q != 2'd3);
            default: begin
            end
        endcase
    end

    // Stretch only where SCL is actually released; START holds SCL low in Q2.
    assign w_hold    = (r_q == 2'd2) && (r_ph == '0) && !w_scl_oe && !scl_i;
    assign w_q_end   = (r_ph == PH_LAST) && !w_hold;
    assign w_sample  = w_q_end && (r_q == 2'd2);
    assign w_bit_end = w_q_end && (r_q == 2'd3);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            r_state <= S_IDLE;
            r_q     <= '0;
            r_ph    <= '0;
            r_bit   <= '0;
            r_k     <= '0;
            r_nb    <= '0;
            r_dev   <= '0;
            r_rw    <= 1'b0;
            r_uwa   <= 1'b0;
            r_rs    <= 1'b0;
            r_waddr <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
            r_sh    <= '0;
            r_sda_s <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_nack  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == S_IDLE) begin
                if (start && !r_done) begin
                    r_state <= S_START;
                    r_busy  <= 1'b1;
                    r_nack  <= 1'b0;
                    r_dev   <= dev_addr;
                    r_rw    <= rw;
                    r_uwa   <= use_waddr;
                    r_waddr <= word_addr;
                    r_nb    <= w_nb;
                    r_wdata <= wdata;
                    r_k     <= '0;
                    r_bit   <= '0;
                    r_q     <= '0;
                    r_ph    <= '0;
                    r_rs    <= 1'b0;
                end
            end else begin
                if (!w_hold) r_ph <= (r_ph == PH_LAST) ? '0 : r_ph + 1'b1;
                if (w_q_end) r_q <= r_q + 2'd1;
                if (w_sample) begin
                    r_sda_s <= sda_i;
                    if (r_state == S_RDATA) r_sh <= {r_sh[6:0], sda_i};
                end
                if (w_bit_end) begin
                    case (r_state)
                        S_START: r_state <= S_ADDR;
                        S_ADDR: begin
                            r_bit <= r_bit + 3'd1;
                            if (r_bit == 3'd7) r_state <= S_AACK;
                        end
                        S_WADDR: begin
                            r_bit <= r_bit + 3'd1;
                            if (r_bit == 3'd7) r_state <= S_WAACK;
                        end
                        S_WDATA: begin
                            r_bit <= r_bit + 3'd1;
                            if (r_bit == 3'd7) r_state <= S_WDACK;
                        end
                        S_RDATA: begin
                            r_bit <= r_bit + 3'd1;
                            if (r_bit == 3'd7) begin
                                r_rdata[{r_k, 3'b000} +: 8] <= r_sh;
                                r_state <= S_MACK;
                            end
                        end
                        S_AACK: begin
                            if (r_sda_s) begin
                                r_nack  <= 1'b1;
                                r_state <= S_STOP;
                            end else if (r_uwa && !r_rs) begin
                                r_state <= S_WADDR;
                            end else begin
                                r_state <= r_rw ? S_RDATA : S_WDATA;
                            end
                        end
                        S_WAACK: begin
                            if (r_sda_s) begin
                                r_nack  <= 1'b1;
                                r_state <= S_STOP;
                            end else begin
                                r_state <= r_rw ? S_RSTART : S_WDATA;
                            end
                        end
                        S_WDACK: begin
                            if (r_sda_s) begin
                                r_nack  <= 1'b1;
                                r_state <= S_STOP;
                            end else begin
                                r_k     <= r_k + CNT_W'(1);
                                r_state <= w_k_last ? S_STOP : S_WDATA;
                            end
                        end
                        S_MACK: begin
                            r_k     <= r_k + CNT_W'(1);
                            r_state <= w_k_last ? S_STOP : S_RDATA;
                        end
                        S_RSTART: begin
                            r_rs    <= 1'b1;
                            r_state <= S_ADDR;
                        end
                        S_STOP: begin
                            r_state <= S_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                        default: r_state <= S_IDLE;
                    endcase
                end
            end
        end
    end

    assign rdata  = r_rdata;
    assign busy   = r_busy;
    assign done   = r_done;
    assign nack   = r_nack;
    assign scl_oe = w_scl_oe;
    assign sda_oe = w_sda_oe;

endmodule
